// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, FSM states
// and the fixed LO value returned for a zero divisor.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on a packed remainder:quotient register.
module mdu_div_step (
    input  logic [63:0] rq,
    input  logic [31:0] divisor,
    output logic [63:0] rq_next
);

    logic [33:0] diff;

    // The shifted remainder can be 33 bits wide, so the trial subtract uses
    // one extra bit and the top bit acts as the borrow.
    always_comb begin
        diff = {1'b0, rq[63:31]} - {2'b00, divisor};
        if (!diff[33]) begin
            rq_next = {diff[31:0], rq[30:0], 1'b1};
        end else begin
            rq_next = {rq[62:31], rq[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MDU_FAST_MUL_EN to replace the shift-add multiply with a one-cycle multiplier.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [63:0]        acc_reg, acc_next;
    logic [31:0]        opnd_reg, opnd_next;
    logic [31:0]        raw_a_reg, raw_a_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               is_div_reg, is_div_next;
    logic               div0_reg, div0_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;

    logic               op_mul, op_div, op_signed, accept, last_iter;
    logic [31:0]        a_abs, b_abs;
    logic [32:0]        mul_sum;
    logic [63:0]        mul_step, div_step;
    logic [63:0]        prod_fix;
    logic [31:0]        quo_fix, rem_fix;

    assign op_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign op_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign accept    = (state_reg == S_IDLE) && start && !cancel;
    assign last_iter = (cnt_reg == CNT_W'(ITERS - 1));
    assign a_abs     = abs_val(data1, op_signed);
    assign b_abs     = abs_val(data2, op_signed);

    // Shift-add: the upper half accumulates, the lower half holds the
    // not-yet-consumed multiplier bits and fills with product bits.
    assign mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opnd_reg : 32'd0)};
    assign mul_step = {mul_sum, acc_reg[31:1]};

    mdu_div_step u_div_step (
        .rq      (acc_reg),
        .divisor (opnd_reg),
        .rq_next (div_step)
    );

    assign prod_fix = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
    assign quo_fix  = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    assign rem_fix  = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_full;
    logic        [63:0] fast_prod;

    assign fast_a    = {op_signed & data1[31], data1};
    assign fast_b    = {op_signed & data2[31], data2};
    assign fast_full = fast_a * fast_b;
    assign fast_prod = fast_full[63:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && op_mul) begin
`ifdef MDU_FAST_MUL_EN
                    state_next = S_FIX;
`else
                    state_next = S_MUL;
`endif
                end else if (accept && op_div) begin
                    state_next = (data2 == 32'd0) ? S_FIX : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (cancel && (state_reg != S_IDLE)) state_next = S_IDLE;
    end

    always_comb begin
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        raw_a_next  = raw_a_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        is_div_next = is_div_reg;
        div0_next   = div0_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;
        busy_next   = (state_next != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (accept && op_mul) begin
                    cnt_next    = '0;
                    opnd_next   = a_abs;
                    is_div_next = 1'b0;
                    div0_next   = 1'b0;
                    neg_r_next  = 1'b0;
`ifdef MDU_FAST_MUL_EN
                    acc_next    = fast_prod;
                    neg_q_next  = 1'b0;
`else
                    acc_next    = {32'd0, b_abs};
                    neg_q_next  = op_signed & (data1[31] ^ data2[31]);
`endif
                end else if (accept && op_div) begin
                    cnt_next    = '0;
                    acc_next    = {32'd0, a_abs};
                    opnd_next   = b_abs;
                    raw_a_next  = data1;
                    neg_q_next  = op_signed & (data1[31] ^ data2[31]);
                    neg_r_next  = op_signed & data1[31];
                    is_div_next = 1'b1;
                    div0_next   = (data2 == 32'd0);
                end else if (accept && (md_op == MD_MTHI)) begin
                    hi_next = data1;
                end else if (accept && (md_op == MD_MTLO)) begin
                    lo_next = data1;
                end
            end
            S_MUL: begin
                acc_next = mul_step;
                cnt_next = cnt_reg + CNT_W'(1);
            end
            S_DIV: begin
                acc_next = div_step;
                cnt_next = cnt_reg + CNT_W'(1);
            end
            S_FIX: begin
                if (!cancel) begin
                    done_next = 1'b1;
                    if (div0_reg) begin
                        hi_next = raw_a_reg;
                        lo_next = DIV0_LO;
                    end else if (is_div_reg) begin
                        hi_next = rem_fix;
                        lo_next = quo_fix;
                    end else begin
                        hi_next = prod_fix[63:32];
                        lo_next = prod_fix[31:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            raw_a_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            raw_a_reg  <= raw_a_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            is_div_reg <= is_div_next;
            div0_reg   <= div0_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} queued at issue, checked on done.
module tb_mdu_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam int LONG_LAT = 33;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = LONG_LAT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b111;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [63:0] sb_q[$];
    string       tag_q[$];

    mdu_ctrl #(.ITERS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .md_op  (md_op),
        .data1  (data1),
        .data2  (data2),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Reference arithmetic in 64-bit signed/unsigned math, independent of the sequencer.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                check_eq(tag_q.pop_front(), {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Issue one op, optionally poke a second start while busy, then measure busy length.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input string tag, input bit poke);
        int lat;
        int d0;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        start = 1'b1; md_op = op; data1 = a; data2 = b;
        @(posedge clk);
        #1 start = 1'b0;
        d0 = done_cnt;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                start = 1'b1; md_op = OP_MULTU; data1 = 32'h1357_9BDF; data2 = 32'h0246_8ACE;
            end else begin
                start = 1'b0;
            end
            if (busy) lat++;
            else break;
        end
        start = 1'b0;
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        check_eq({tag, "_done1"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; md_op = op; data1 = v;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        if (op == OP_MTHI) check_eq("mthi_hi", {32'd0, hi}, {32'd0, v});
        else               check_eq("mtlo_lo", {32'd0, lo}, {32'd0, v});
        check_eq("mt_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          d0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, "mult_neg3x7", 1'b0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, "multu_max", 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT, "mult_minsq", 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, LONG_LAT, "div_neg7by2", 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,        64'h0000_0002_0000_000E, LONG_LAT, "divu_100by7", 1'b0);
        run_op(OP_DIVU,  32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 1,        "divu_by0", 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, LONG_LAT, "div_ovf", 1'b0);
        run_op(OP_MULT,  32'h0001_2345, 32'hFFFF_0010, model(OP_MULT, 32'h0001_2345, 32'hFFFF_0010),
               MUL_LAT, "mult_busy_poke", 1'b1);

        for (int k = 0; k < 8; k++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (k == 5) b = 32'd0;
            run_op(op, a, b, model(op, a, b),
                   (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : ((b == 32'd0) ? 1 : LONG_LAT),
                   $sformatf("rand%0d_op%0d", k, op), 1'b0);
        end

        move_to(OP_MTHI, 32'h0000_1234);
        move_to(OP_MTHI, 32'h0000_000A);
        move_to(OP_MTLO, 32'h0000_000B);

        // Cancel an in-flight DIV: no done, HI/LO untouched.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; md_op = OP_DIV; data1 = 32'd1000; data2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check_eq("cancel_busy", {63'd0, busy}, 64'd0);
        check_eq("cancel_hilo", {hi, lo}, 64'h0000_000A_0000_000B);
        repeat (40) @(posedge clk);
        #1;
        check_eq("cancel_nodone", 64'(done_cnt - d0), 64'd0);
        check_eq("cancel_hilo_late", {hi, lo}, 64'h0000_000A_0000_000B);

        // Cancel together with start in IDLE drops an MTLO.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = OP_MTLO; data1 = 32'h5555_5555;
        @(posedge clk);
        #1 begin start = 1'b0; cancel = 1'b0; end
        @(negedge clk);
        check_eq("cancel_mtlo_lo", {32'd0, lo}, 64'h0000_000B);
        check_eq("cancel_mtlo_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a MULT.
        @(negedge clk);
        start = 1'b1; md_op = OP_MULT; data1 = 32'd9; data2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", {63'd0, busy}, 64'd0);
        check_eq("midrst_done", {63'd0, done}, 64'd0);
        check_eq("midrst_hilo", {hi, lo}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("midrst_hilo_late", {hi, lo}, 64'd0);

        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Iterative multiply/divide controller for the MIPS core. It executes MULT, MULTU, DIV and DIVU with a radix-2 shift-add and restoring-subtract sequencer, and owns the HI/LO architectural registers. It sits beside the single-cycle ALU in EX and drives `busy` so the pipeline stalls MFHI/MFLO and further MDU ops until the result lands. Exceptions in EX/MEM can cancel an in-flight op.

Parameters:
- ITERS, 32, number of iteration cycles per MULT/DIV (one bit per cycle).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  op request; sampled only when busy=0
- md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
- data1  in  32  rs operand (multiplicand/dividend; MTHI/MTLO source)
- data2  in  32  rt operand (multiplier/divisor)
- cancel  in  1  abort the in-flight op; HI/LO keep their old values
- busy  out  1  registered; high while an op is in flight
- hi  out  32  HI register
- lo  out  32  LO register
- done  out  1  one-cycle pulse on the edge HI/LO take a MULT/DIV result

Behaviour:
- Reset (rst=1 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0; iteration counter=0. Reset mid-op aborts it.
- States:
  - IDLE
  - MUL: ITERS cycles
  - DIV: ITERS cycles
  - FIX: 1 cycle for sign fix-up and the HI/LO write
  - busy = (state != IDLE).
- IDLE, start=1, cancel=0:
  - MULT/MULTU/DIV/DIVU: latch |data1|, |data2| (absolute values for signed ops; raw for unsigned), latch result signs; go to MUL or DIV; counter=0.
  - MTHI/MTLO: write hi or lo at that edge. State stays IDLE, busy stays 0, no done pulse.
  - NOP codes are ignored.
- start while busy=1 is ignored; the pipeline must hold the request until busy=0.
- MUL: 64-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV: 64-bit remainder:quotient shift register, one restoring step per cycle.
- Transitions:
  - Counter reaches ITERS-1 → FIX.
  - FIX → IDLE at the next edge. At that edge: hi/lo written, done=1 for that cycle.
- Latency: start accepted at edge E0. busy=1 after E0 through E(ITERS+1). hi/lo and done update at E(ITERS+1), i.e. E33 by default. busy=0 after E33.
- Sign rules:
  - MULT: 64-bit product is negated if the operand signs differ.
  - DIV: quotient is negated if the signs differ; remainder takes the sign of data1.
  - All arithmetic is two's complement modulo 2^32 per register.
- Boundary cases:
  - Divisor 0 (DIV/DIVU): skip DIV; go straight to FIX on the next edge; result hi=data1, lo=32'hFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- cancel=1 at any edge with state != IDLE: go to IDLE; hi/lo unchanged; done=0.
  - cancel has priority over FIX completion.
  - cancel=1 together with start in IDLE: the request is dropped, including MTHI/MTLO.
- rst has priority over cancel and start.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a combinational 64-bit signed/unsigned multiply.
  - The operation goes IDLE → FIX directly: busy high for 1 cycle; hi/lo and done at E1.
  - DIV is unchanged.
- Undefined: the iterative path above; MULT latency is ITERS+1 cycles.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encodings (MD_MULT..MD_MTLO)
  - state encoding (S_IDLE, S_MUL, S_DIV, S_FIX)
  - DIV0_LO = 32'hFFFFFFFF
- One sub-module, mdu_div_step: combinational restoring step.
  - Input: 64-bit rem:quo and the 32-bit divisor.
  - Output: next rem:quo.
  - It is reused for unit testing.

Test Plan:
- MULT data1=0xFFFFFFFD (-3), data2=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; busy low on the following cycle.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 5 / 0 → busy for 1 cycle; hi=5, lo=0xFFFFFFFF. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- Sequencing:
  - MTHI 0x1234 while idle → hi=0x1234 next cycle, busy stays 0.
  - start MULT while busy → ignored; the in-flight result is unaffected.
- Cancel and reset:
  - Prior hi=0xA, lo=0xB; start DIV; cancel at cycle 10 → busy=0 next cycle, hi/lo stay 0xA/0xB, no done pulse.
  - rst at cycle 5 of a MULT → all outputs 0.
